// File: rtl/fp_conv_pkg.sv
// rtl/fp_conv_pkg.sv - shared widths, limits and FSM states for the 12-bit to mini-float converter
package fp_conv_pkg;

  localparam int DATA_W = 12;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    RND,
    OUT
  } state_t;

endpackage

// File: rtl/fp_rr_arbiter.sv
// rtl/fp_rr_arbiter.sv - round-robin one-hot grant starting the search at ptr, wrapping
module fp_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    sum    = '0;
    idx    = '0;
    if (en) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        sum = {1'b0, ptr} + (ID_W + 1)'(i);
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
          sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        idx = sum[ID_W-1:0];
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_id   = idx;
        end
      end
    end
  end

endmodule

// File: rtl/fp_conv_sched.sv
// rtl/fp_conv_sched.sv - shared 12-bit two's-complement to sign/exp3/sig4 converter with round-robin requesters
// Optional FP_CONV_OVF_FLAG_EN adds the registered out_ovf saturation flag.
module fp_conv_sched
  import fp_conv_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [EXP_W-1:0]          out_exp,
  output logic [SIG_W-1:0]          out_sig,
  output logic [ID_W-1:0]           out_id
`ifdef FP_CONV_OVF_FLAG_EN
  ,
  output logic                      out_ovf
`endif
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic [DATA_W-1:0]   data_q;
  logic [ID_W-1:0]     id_q;
  logic                sign_q;
  logic [EXP_W-1:0]    exp_q;
  logic [SIG_W-1:0]    sig_q;
  logic                fifth_q;
  logic                sat_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                hs;

  logic [DATA_W-1:0]   mag;
  logic [3:0]          lead;
  logic [10:0]         shifted;
  logic [EXP_W-1:0]    enc_exp;
  logic [SIG_W-1:0]    enc_sig;
  logic                enc_fifth;
  logic                enc_sat;

  logic [SIG_W:0]      rnd_sum;
  logic                rnd_sat;
  logic [EXP_W-1:0]    rnd_exp;
  logic [SIG_W-1:0]    rnd_sig;

  fp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (state_q == IDLE),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  // Sign-magnitude plus leading-one encode; 12'h800 has no positive 12-bit magnitude.
  always_comb begin
    mag       = data_q[DATA_W-1] ? (~data_q + 12'd1) : data_q;
    enc_sat   = (mag == 12'h800);
    lead      = '0;
    for (int b = 0; b <= 10; b++) begin
      if (mag[b]) lead = 4'(b);
    end
    shifted   = mag[10:0] >> (lead - 4'd4);
    enc_exp   = '0;
    enc_sig   = mag[SIG_W-1:0];
    enc_fifth = 1'b0;
    if (lead >= 4'd4) begin
      enc_exp   = 3'(lead - 4'd3);
      enc_sig   = shifted[4:1];
      enc_fifth = shifted[0];
    end
  end

  always_comb begin
    rnd_sum = {1'b0, sig_q} + 5'(fifth_q);
    rnd_sat = sat_q | (rnd_sum[SIG_W] & (exp_q == EXP_MAX));
    rnd_exp = exp_q;
    rnd_sig = rnd_sum[SIG_W-1:0];
    if (rnd_sat) begin
      rnd_exp = EXP_MAX;
      rnd_sig = SIG_MAX;
    end else if (rnd_sum[SIG_W]) begin
      rnd_exp = exp_q + 3'd1;
      rnd_sig = 4'b1000;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (hs) state_d = ENC;
      ENC:  state_d = RND;
      RND:  state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      data_q   <= '0;
      id_q     <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      sig_q    <= '0;
      fifth_q  <= 1'b0;
      sat_q    <= 1'b0;
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_sig  <= '0;
      out_id   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (hs) begin
          data_q <= req_data[DATA_W*int'(gnt_id) +: DATA_W];
          id_q   <= gnt_id;
          ptr_q  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        ENC: begin
          sign_q  <= data_q[DATA_W-1];
          exp_q   <= enc_exp;
          sig_q   <= enc_sig;
          fifth_q <= enc_fifth;
          sat_q   <= enc_sat;
        end
        RND: begin
          out_sign <= sign_q;
          out_exp  <= rnd_exp;
          out_sig  <= rnd_sig;
          out_id   <= id_q;
        end
        default: ;
      endcase
    end
  end

`ifdef FP_CONV_OVF_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (state_q == RND) begin
      out_ovf <= rnd_sat;
    end
  end
`else
  // Saturation is visible only as exp=7/sig=15.
`endif

endmodule

// File: tb/tb_fp_conv_sched.sv
// tb/tb_fp_conv_sched.sv - scoreboard bench for fp_conv_sched; honours FP_CONV_OVF_FLAG_EN
module tb_fp_conv_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_sig;
  logic [1:0]  out_id;
`ifdef FP_CONV_OVF_FLAG_EN
  logic        out_ovf;
`endif

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] g;
    logic [1:0] id;
    logic       ovf;
    int         due;
    bit         lat;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fp_conv_sched #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_sig   (out_sig),
    .out_id    (out_id)
`ifdef FP_CONV_OVF_FLAG_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic [2:0] e, input logic [3:0] g,
                              input logic [1:0] id, input logic ovf, input bit lat);
    exp_t r;
    r.s = s; r.e = e; r.g = g; r.id = id; r.ovf = ovf; r.due = 0; r.lat = lat;
    return r;
  endfunction

  // Monitor: every accepted result must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got id %0d exp %0d sig %0d want none", out_id, out_exp, out_sig);
        end else begin
          m = q.pop_front();
          chk("res_sign", 32'(out_sign), 32'(m.s));
          chk("res_exp",  32'(out_exp),  32'(m.e));
          chk("res_sig",  32'(out_sig),  32'(m.g));
          chk("res_id",   32'(out_id),   32'(m.id));
          if (m.lat) chk("res_latency_cycle", 32'(cyc), 32'(m.due));
`ifdef FP_CONV_OVF_FLAG_EN
          chk("res_ovf", 32'(out_ovf), 32'(m.ovf));
`endif
        end
      end
    end
  end

  task automatic send(input int id, input logic [11:0] d, input exp_t e);
    int t;
    exp_t x;
    x = e;
    @(negedge clk);
    req_data[12*id +: 12] = d;
    req_valid[id] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[id] && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!req_ready[id]) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout req %0d got req_ready %b want grant", id, req_ready);
      req_valid[id] = 1'b0;
    end else begin
      x.due = cyc + 3;
      q.push_back(x);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
    end
  endtask

  exp_t hold_tab[4];
  int   seq_id[5] = '{0, 1, 2, 3, 0};

  initial begin
    int n, t, prev;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_outputs", 32'({out_sign, out_exp, out_sig, out_id}), 32'd0);
`ifdef FP_CONV_OVF_FLAG_EN
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
    rst = 1'b0;

    send(0, 12'd0,    mk(1'b0, 3'd0, 4'd0,  2'd0, 1'b0, 1'b1)); drain();
    send(2, 12'd422,  mk(1'b0, 3'd5, 4'd13, 2'd2, 1'b0, 1'b1)); drain();
    send(3, 12'd124,  mk(1'b0, 3'd4, 4'd8,  2'd3, 1'b0, 1'b1)); drain();
    send(1, 12'hFFF,  mk(1'b1, 3'd0, 4'd1,  2'd1, 1'b0, 1'b1)); drain();
    send(0, 12'h800,  mk(1'b1, 3'd7, 4'd15, 2'd0, 1'b1, 1'b1)); drain();
    send(1, 12'd2047, mk(1'b0, 3'd7, 4'd15, 2'd1, 1'b1, 1'b1)); drain();
    send(2, 12'd1920, mk(1'b0, 3'd7, 4'd15, 2'd2, 1'b0, 1'b1)); drain();

    // Fresh pointer, then all four requesters held valid.
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_tab[0] = mk(1'b0, 3'd0, 4'd0,  2'd0, 1'b0, 1'b1);
    hold_tab[1] = mk(1'b0, 3'd5, 4'd13, 2'd1, 1'b0, 1'b1);
    hold_tab[2] = mk(1'b1, 3'd0, 4'd1,  2'd2, 1'b0, 1'b1);
    hold_tab[3] = mk(1'b0, 3'd4, 4'd8,  2'd3, 1'b0, 1'b1);
    req_data = {12'd124, 12'hFFF, 12'd422, 12'd0};
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    n = 0; t = 0; prev = 0;
    while (n < 5 && t < 60) begin
      if (|(req_valid & req_ready)) begin
        m = hold_tab[seq_id[n]];
        m.due = cyc + 3;
        q.push_back(m);
        if (n > 0) chk("rr_issue_spacing", 32'(cyc - prev), 32'd4);
        prev = cyc;
        n++;
        if (n == 5) begin
          @(posedge clk);
          #1;
          req_valid = '0;
        end
      end
      if (n < 5) begin
        @(negedge clk);
        #1;
        t++;
      end
    end
    if (n < 5) begin
      checks++;
      errors++;
      $display("FAIL rr_timeout got %0d grants want 5", n);
      req_valid = '0;
    end
    drain();

    // Back-pressure: result must hold and no grant may issue.
    out_ready = 1'b0;
    send(2, 12'd1920, mk(1'b0, 3'd7, 4'd15, 2'd2, 1'b0, 1'b0));
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("stall_out_valid_rise", 32'(out_valid), 32'd1);
    req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_outputs", 32'({out_sign, out_exp, out_sig, out_id}), 32'({1'b0, 3'd7, 4'd15, 2'd2}));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid[3] = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset while the sample sits in RND; pointer is nonzero beforehand.
    @(negedge clk);
    req_data[12 +: 12] = 12'd2047;
    req_valid[1] = 1'b1;
    #1;
    t = 0;
    while (!req_ready[1] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("abort_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_req_ready_ptr0", 32'(req_ready), 32'h1);
    req_valid = '0;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
